// File: rtl/siftkey_pkg.sv
// Shared sifting package: FSM state codes and default key-store geometry.
package siftkey_pkg;

    localparam int SIFT_DATA_W = 64;
    localparam int SIFT_ADDR_W = 15;

    // State codes are also driven onto the LED port, so the encoding is fixed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } sift_state_t;

    // True in the states that still accept key words from the sifting engine.
    function automatic logic accepts_writes(input sift_state_t s);
        return (s == ST_IDLE) || (s == ST_COLLECT);
    endfunction

endpackage

// File: rtl/siftkey_sdp_ram.sv
// Simple dual-port key store: one write port, one registered read port
// with 1-cycle latency, written so synthesis maps it onto block RAM.
module siftkey_sdp_ram
    import siftkey_pkg::*;
#(
    parameter int DATA_W = SIFT_DATA_W,
    parameter int ADDR_W = SIFT_ADDR_W
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    // Write port.
    // NOTE: the array has no reset -- a reset loop over every word would stop it mapping to BRAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; the word appears one cycle after i_rd_en.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/siftkey_collector.sv
// Sifted-key collector: captures key words written by the sifting engine,
// then drains them in address order over a valid/ready stream.
module siftkey_collector
    import siftkey_pkg::*;
#(
    parameter int DATA_W = SIFT_DATA_W,
    parameter int ADDR_W = SIFT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] key_dina,
    input  logic [ADDR_W-1:0] key_addra,
    input  logic              key_ena,
    input  logic              key_wea,
    input  logic              sifting_finish,
    input  logic              clear,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [ADDR_W:0]   key_count,
    output logic              busy,
    output logic              done,
    output logic              drop_err,
    output logic [1:0]        state
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    sift_state_t       r_state;
    sift_state_t       w_state_next;
    logic [ADDR_W:0]   r_key_count;
    logic [ADDR_W:0]   w_count_next;
    logic [ADDR_W:0]   w_addr_plus1;
    logic              r_drop_err;

    logic              w_write;
    logic              w_wr_accept;
    logic              w_wr_drop;

    // Read side: r_rd_addr counts words already requested from the RAM.
    logic [ADDR_W:0]   r_rd_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_issue;

    // Two-entry output buffer; entry 0 is the head presented on the stream.
    logic [1:0]        r_fifo_cnt;
    logic [DATA_W-1:0] r_buf0_data;
    logic [DATA_W-1:0] r_buf1_data;
    logic              r_buf0_last;
    logic              r_buf1_last;
    logic              w_m_valid;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ_after_pop;

    assign w_write      = key_ena & key_wea;
    assign w_wr_accept  = w_write & accepts_writes(r_state) & ~clear;
    assign w_wr_drop    = w_write & ~accepts_writes(r_state) & ~clear;
    assign w_addr_plus1 = {1'b0, key_addra} + CNT_ONE;
    assign w_count_next = (w_wr_accept && (w_addr_plus1 > r_key_count)) ? w_addr_plus1 : r_key_count;

    assign w_m_valid = (r_fifo_cnt != 2'd0);
    assign w_pop     = w_m_valid & m_ready;
    assign w_push    = r_inflight;

    // A read is requested only if its word is sure to find a free buffer
    // entry when it returns; counting this cycle's pop keeps full throughput.
    assign w_occ_after_pop = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == ST_DRAIN) && (r_rd_addr < r_key_count)
                     && (w_occ_after_pop < 3'd2) && !clear;

    siftkey_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (key_addra),
        .i_wr_data (key_dina),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_rd_addr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    // Next-state selection; clear overrides every other event.
    always_comb begin
        // NOTE: default assigned first so every path drives w_state_next and no latch is inferred.
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_write) begin
                        w_state_next = sifting_finish ? ST_DRAIN : ST_COLLECT;
                    end else if (sifting_finish) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_COLLECT: begin
                    if (sifting_finish) begin
                        w_state_next = (w_count_next != '0) ? ST_DRAIN : ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && r_buf0_last) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE:  w_state_next = ST_DONE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Captured word count (high-water address + 1) and sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_count <= '0;
            r_drop_err  <= 1'b0;
        end else if (clear) begin
            r_key_count <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_key_count <= w_count_next;
            if (w_wr_drop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Read request counter and in-flight tracking for the 1-cycle RAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == (r_key_count - CNT_ONE));
            if (clear || (r_state != ST_DRAIN)) begin
                r_rd_addr <= '0;
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr + CNT_ONE;
            end
        end
    end

    // Output buffer: RAM words enter at the tail, the head holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_cnt  <= 2'd0;
            r_buf0_data <= '0;
            r_buf1_data <= '0;
            r_buf0_last <= 1'b0;
            r_buf1_last <= 1'b0;
        end else if (clear) begin
            r_fifo_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_fifo_cnt == 2'd0) begin
                        r_buf0_data <= w_rd_data;
                        r_buf0_last <= r_inflight_last;
                    end else begin
                        r_buf1_data <= w_rd_data;
                        r_buf1_last <= r_inflight_last;
                    end
                    r_fifo_cnt <= r_fifo_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0_data <= r_buf1_data;
                    r_buf0_last <= r_buf1_last;
                    r_fifo_cnt  <= r_fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_fifo_cnt == 2'd1) begin
                        r_buf0_data <= w_rd_data;
                        r_buf0_last <= r_inflight_last;
                    end else begin
                        r_buf0_data <= r_buf1_data;
                        r_buf0_last <= r_buf1_last;
                        r_buf1_data <= w_rd_data;
                        r_buf1_last <= r_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid   = w_m_valid;
    assign m_data    = r_buf0_data;
    assign m_last    = r_buf0_last & w_m_valid;
    assign key_count = r_key_count;
    assign busy      = (r_state == ST_COLLECT) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign drop_err  = r_drop_err;
    assign state     = r_state;

endmodule

// File: tb/tb_siftkey_collector.sv
// Self-checking bench for siftkey_collector: scenario tasks with a
// behavioural key-store model (address -> word map plus high-water count).
module tb_siftkey_collector;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] key_dina = '0;
    logic [ADDR_W-1:0] key_addra = '0;
    logic              key_ena = 1'b0;
    logic              key_wea = 1'b0;
    logic              sifting_finish = 1'b0;
    logic              clear = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [ADDR_W:0]   key_count;
    logic              busy;
    logic              done;
    logic              drop_err;
    logic [1:0]        state;

    always #5 clk = ~clk;

    siftkey_collector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .key_dina(key_dina), .key_addra(key_addra),
        .key_ena(key_ena), .key_wea(key_wea), .sifting_finish(sifting_finish),
        .clear(clear), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .key_count(key_count), .busy(busy), .done(done),
        .drop_err(drop_err), .state(state)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: storage survives clear/reset, so it is never erased here.
    logic [DATA_W-1:0] mem_model [int];
    int                exp_count = 0;

    // Pending write list consumed by do_writes.
    int                wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];

    // Stream observed by run_drain.
    logic [DATA_W-1:0] got_data [$];
    bit                got_last [$];
    int                stall_viol;
    int                first_valid;
    int                bubbles;
    bit                timed_out;

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // Drive queued writes back to back; optionally raise sifting_finish with the last.
    task automatic do_writes(input bit finish_with_last);
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            @(negedge clk);
            key_ena = 1'b1;
            key_wea = 1'b1;
            key_addra = wr_addr_q[i][ADDR_W-1:0];
            key_dina = wr_data_q[i];
            sifting_finish = finish_with_last && (i == wr_addr_q.size() - 1);
            mem_model[wr_addr_q[i]] = wr_data_q[i];
            if (wr_addr_q[i] + 1 > exp_count) exp_count = wr_addr_q[i] + 1;
        end
        @(negedge clk);
        key_ena = 1'b0;
        key_wea = 1'b0;
        sifting_finish = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic pulse_finish();
        @(negedge clk);
        sifting_finish = 1'b1;
        @(negedge clk);
        sifting_finish = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_count = 0;
    endtask

    // Collect n_max beats. ready_mode: 0 always ready, 1 toggle 1/0, 2 random.
    // At cycle inject_cyc a write (to the last address) and a finish pulse are driven.
    task automatic run_drain(input int ready_mode, input int n_max, input int inject_cyc);
        bit                prev_stall = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        logic              prev_last = 1'b0;
        bit                rdy;
        int                cyc = 0;
        got_data.delete();
        got_last.delete();
        stall_viol = 0;
        first_valid = -1;
        bubbles = 0;
        timed_out = 1'b0;
        while (got_data.size() < n_max) begin
            if (cyc >= 8 * n_max + 20) begin
                timed_out = 1'b1;
                break;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            m_ready = rdy;
            if (cyc == inject_cyc) begin
                key_ena = 1'b1;
                key_wea = 1'b1;
                key_addra = ADDR_W'(n_max - 1);
                key_dina = rand_word();
                sifting_finish = 1'b1;
            end else begin
                key_ena = 1'b0;
                key_wea = 1'b0;
                sifting_finish = 1'b0;
            end
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
            if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (ready_mode == 0 && first_valid >= 0 && m_valid !== 1'b1) bubbles++;
            if (m_valid === 1'b1 && rdy) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
            end
            prev_stall = (m_valid === 1'b1) && !rdy;
            prev_data = m_data;
            prev_last = m_last;
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        key_ena = 1'b0;
        key_wea = 1'b0;
        sifting_finish = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (key_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", key_count); end
        checks++; if ({m_valid, m_last, busy, done, drop_err} !== 5'b0) begin errors++; $display("FAIL reset_flags valid/last/busy/done/drop got=%b exp=00000", {m_valid, m_last, busy, done, drop_err}); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", m_data); end
        exp_count = 0;
    endtask

    task automatic test_sequential();
        for (int a = 0; a < 8; a++) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(DATA_W'(64'h100 + a));
        end
        do_writes(1'b0);
        checks++; if (state !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL seq_collect state=%0d busy=%b exp state=1 busy=1", state, busy); end
        checks++; if (key_count !== exp_count[ADDR_W:0]) begin errors++; $display("FAIL seq_count got=%0d exp=%0d", key_count, exp_count); end
        pulse_finish();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL seq_drain_entry got=%0d exp=2", state); end
        run_drain(0, 8, -1);
        checks++; if (timed_out || got_data.size() != 8) begin errors++; $display("FAIL seq_len got=%0d exp=8", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== DATA_W'(64'h100 + i) || got_last[i] !== (i == 7)) begin errors++; $display("FAIL seq_beat%0d got=%h last=%b exp=%h last=%b", i, got_data[i], got_last[i], 64'h100 + i, i == 7); end
        end
        checks++; if (first_valid < 0 || first_valid > 2) begin errors++; $display("FAIL seq_latency got=%0d exp<=2", first_valid); end
        checks++; if (bubbles != 0) begin errors++; $display("FAIL seq_bubbles got=%0d exp=0", bubbles); end
        checks++; if (state !== 2'd3 || done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL seq_done state=%0d done=%b busy=%b valid=%b exp 3/1/0/0", state, done, busy, m_valid); end
        checks++; if (key_count !== 16'd8) begin errors++; $display("FAIL seq_final_count got=%0d exp=8", key_count); end
        do_clear();
        checks++; if (state !== 2'd0 || key_count !== '0) begin errors++; $display("FAIL seq_clear state=%0d count=%0d exp 0/0", state, key_count); end
    endtask

    task automatic test_backpressure();
        for (int a = 0; a < 4; a++) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(rand_word());
        end
        do_writes(1'b0);
        pulse_finish();
        run_drain(1, 4, -1);
        checks++; if (timed_out || got_data.size() != 4) begin errors++; $display("FAIL bp_len got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== mem_model[i] || got_last[i] !== (i == 3)) begin errors++; $display("FAIL bp_beat%0d got=%h last=%b exp=%h last=%b", i, got_data[i], got_last[i], mem_model[i], i == 3); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d changes exp=0", stall_viol); end
        checks++; if (state !== 2'd3 || m_valid !== 1'b0) begin errors++; $display("FAIL bp_done state=%0d valid=%b exp 3/0", state, m_valid); end
        do_clear();
    endtask

    task automatic test_sparse();
        wr_addr_q.push_back(5); wr_data_q.push_back(rand_word());
        wr_addr_q.push_back(2); wr_data_q.push_back(rand_word());
        do_writes(1'b0);
        checks++; if (key_count !== 16'd6) begin errors++; $display("FAIL sparse_count got=%0d exp=6", key_count); end
        wr_addr_q.push_back(2); wr_data_q.push_back(rand_word());
        do_writes(1'b0);
        checks++; if (key_count !== 16'd6) begin errors++; $display("FAIL sparse_rewrite_count got=%0d exp=6", key_count); end
        pulse_finish();
        run_drain(2, 6, -1);
        checks++; if (timed_out || got_data.size() != 6) begin errors++; $display("FAIL sparse_len got=%0d exp=6", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if ((mem_model.exists(i) && got_data[i] !== mem_model[i]) || got_last[i] !== (i == 5)) begin errors++; $display("FAIL sparse_beat%0d got=%h last=%b exp last=%b", i, got_data[i], got_last[i], i == 5); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL sparse_stable got=%0d exp=0", stall_viol); end
        do_clear();
    endtask

    task automatic test_empty();
        int seen_valid = 0;
        pulse_finish();
        checks++; if (state !== 2'd3 || done !== 1'b1 || key_count !== '0) begin errors++; $display("FAIL empty_done state=%0d done=%b count=%0d exp 3/1/0", state, done, key_count); end
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen_valid++;
        end
        m_ready = 1'b0;
        checks++; if (seen_valid != 0) begin errors++; $display("FAIL empty_valid got=%0d cycles exp=0", seen_valid); end
        pulse_finish();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL empty_finish_ignored got=%0d exp=3", state); end
        do_clear();
    endtask

    task automatic test_write_finish_same();
        for (int a = 0; a < 4; a++) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(rand_word());
        end
        do_writes(1'b1);
        checks++; if (state !== 2'd2 || key_count !== 16'd4) begin errors++; $display("FAIL wf_entry state=%0d count=%0d exp 2/4", state, key_count); end
        run_drain(0, 4, -1);
        checks++; if (timed_out || got_data.size() != 4) begin errors++; $display("FAIL wf_len got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== mem_model[i] || got_last[i] !== (i == 3)) begin errors++; $display("FAIL wf_beat%0d got=%h exp=%h", i, got_data[i], mem_model[i]); end
        end
        do_clear();
    endtask

    task automatic test_drop();
        for (int a = 0; a < 5; a++) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(rand_word());
        end
        do_writes(1'b0);
        pulse_finish();
        run_drain(2, 5, 1);
        checks++; if (timed_out || got_data.size() != 5) begin errors++; $display("FAIL drop_len got=%0d exp=5", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== mem_model[i] || got_last[i] !== (i == 4)) begin errors++; $display("FAIL drop_beat%0d got=%h exp=%h", i, got_data[i], mem_model[i]); end
        end
        checks++; if (drop_err !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL drop_flag drop=%b state=%0d exp 1/3", drop_err, state); end
        do_clear();
        checks++; if (drop_err !== 1'b0 || state !== 2'd0 || key_count !== '0) begin errors++; $display("FAIL drop_clear drop=%b state=%0d count=%0d exp 0/0/0", drop_err, state, key_count); end
    endtask

    task automatic test_clear_mid_drain();
        int seen_valid = 0;
        for (int a = 0; a < 6; a++) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(rand_word());
        end
        do_writes(1'b0);
        pulse_finish();
        repeat (4) @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== mem_model[0]) begin errors++; $display("FAIL cmd_head valid=%b data=%h exp 1/%h", m_valid, m_data, mem_model[0]); end
        do_clear();
        checks++; if (m_valid !== 1'b0 || state !== 2'd0 || key_count !== '0) begin errors++; $display("FAIL cmd_clear valid=%b state=%0d count=%0d exp 0/0/0", m_valid, state, key_count); end
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen_valid++;
        end
        m_ready = 1'b0;
        checks++; if (seen_valid != 0) begin errors++; $display("FAIL cmd_quiet got=%0d cycles exp=0", seen_valid); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int n = $urandom_range(1, 10);
            bit fl = 1'(($urandom_range(0, 1)));
            for (int k = 0; k < n; k++) begin
                wr_addr_q.push_back($urandom_range(0, 15));
                wr_data_q.push_back(rand_word());
            end
            do_writes(fl);
            if (!fl) pulse_finish();
            checks++; if (key_count !== exp_count[ADDR_W:0]) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, key_count, exp_count); end
            run_drain(2, exp_count, -1);
            checks++; if (timed_out || got_data.size() != exp_count) begin errors++; $display("FAIL rnd%0d_len got=%0d exp=%0d", r, got_data.size(), exp_count); end
            for (int i = 0; i < got_data.size(); i++) begin
                checks++; if ((mem_model.exists(i) && got_data[i] !== mem_model[i]) || got_last[i] !== (i == exp_count - 1)) begin errors++; $display("FAIL rnd%0d_beat%0d got=%h last=%b", r, i, got_data[i], got_last[i]); end
            end
            checks++; if (stall_viol != 0 || state !== 2'd3) begin errors++; $display("FAIL rnd%0d_end stall=%0d state=%0d exp 0/3", r, stall_viol, state); end
            do_clear();
        end
    endtask

    task automatic test_full_depth();
        wr_addr_q.push_back((1 << ADDR_W) - 1);
        wr_data_q.push_back(rand_word());
        do_writes(1'b0);
        checks++; if (key_count !== 16'd32768 || state !== 2'd1) begin errors++; $display("FAIL full_count got=%0d state=%0d exp 32768/1", key_count, state); end
        wr_addr_q.push_back(100);
        wr_data_q.push_back(rand_word());
        do_writes(1'b0);
        checks++; if (key_count !== 16'd32768) begin errors++; $display("FAIL full_hold got=%0d exp=32768", key_count); end
        do_clear();
    endtask

    task automatic test_reset_mid_drain();
        int beats = 0;
        int c = 0;
        int seen_valid = 0;
        for (int a = 0; a < 10; a++) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(rand_word());
        end
        do_writes(1'b0);
        pulse_finish();
        m_ready = 1'b1;
        while (beats < 3 && c < 40) begin
            if (m_valid === 1'b1) beats++;
            c++;
            if (beats < 3) @(negedge clk);
        end
        checks++; if (beats != 3) begin errors++; $display("FAIL rmd_beats got=%0d exp=3", beats); end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || state !== 2'd0 || key_count !== '0) begin errors++; $display("FAIL rmd_abort valid=%b state=%0d count=%0d exp 0/0/0", m_valid, state, key_count); end
        checks++; if ({m_last, busy, done, drop_err} !== 4'b0 || m_data !== '0) begin errors++; $display("FAIL rmd_outputs last/busy/done/drop=%b data=%h exp 0000/0", {m_last, busy, done, drop_err}, m_data); end
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen_valid++;
        end
        m_ready = 1'b0;
        checks++; if (seen_valid != 0 || state !== 2'd0) begin errors++; $display("FAIL rmd_quiet valid_cycles=%0d state=%0d exp 0/0", seen_valid, state); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_sparse();
        test_empty();
        test_write_finish_same();
        test_drop();
        test_clear_mid_drain();
        test_random();
        test_full_depth();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/siftkey_collector.md
SIFTKEY_COLLECTOR -- requirements
Module: siftkey_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 64, sifted-key word width.
REQ-002 SHALL have parameter ADDR_W, default 15, key-word address width (depth 2**ADDR_W = 32768).
REQ-003 SHALL have port clk, input, 1, single clock for all logic (100 MHz sifting domain).
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port key_dina, input, DATA_W, sifted-key word from the sifting engine's BRAM port A.
REQ-006 SHALL have port key_addra, input, ADDR_W, word address of key_dina.
REQ-007 SHALL have ports key_ena and key_wea, input, 1 each; a write occurs when both are high.
REQ-008 SHALL have port sifting_finish, input, 1, single-cycle end-of-sifting pulse.
REQ-009 SHALL have port clear, input, 1, single-cycle pulse that returns the block to IDLE.
REQ-010 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_W, m_last output 1, the key drain stream.
REQ-011 SHALL have port key_count, output, ADDR_W+1, number of key words captured.
REQ-012 SHALL have ports busy, done, drop_err, output, 1 each, and state, output, 2, FSM code for LEDs.

Function
REQ-013 SHALL implement FSM IDLE(0), COLLECT(1), DRAIN(2), DONE(3).
REQ-014 IDLE: a write SHALL store the word and move to COLLECT; sifting_finish with no write SHALL move to DONE with key_count 0.
REQ-015 COLLECT: each write SHALL store key_dina at key_addra; key_count SHALL become max(key_count, key_addra+1).
REQ-016 Re-writing an already-written address SHALL overwrite the word and leave key_count unchanged.
REQ-017 Write and sifting_finish in the same cycle SHALL store the write, update key_count, then leave COLLECT.
REQ-018 sifting_finish in COLLECT SHALL move to DRAIN if key_count>0, else DONE.
REQ-019 DRAIN: words SHALL be emitted in address order 0..key_count-1 over m_data, one per m_valid&m_ready cycle.
REQ-020 First m_valid SHALL assert no later than 2 cycles after entering DRAIN; with m_ready held high, one word SHALL transfer per cycle (no bubbles).
REQ-021 m_valid, m_data, m_last SHALL hold stable while m_valid&!m_ready.
REQ-022 m_last SHALL be high exactly with the word at address key_count-1; its handshake SHALL move to DONE.
REQ-023 Writes outside IDLE/COLLECT SHALL be discarded and set drop_err (sticky until clear or reset).
REQ-024 sifting_finish outside IDLE/COLLECT SHALL be ignored.
REQ-025 busy SHALL be high in COLLECT and DRAIN; done SHALL be high only in DONE.
REQ-026 clear SHALL take priority over every other event in any state: next cycle IDLE, key_count 0, m_valid 0, drop_err 0; memory contents need not be erased.
REQ-027 key_count SHALL reach 2**ADDR_W (full depth) without wrapping.

Reset
REQ-028 On reset: state IDLE, key_count 0, m_valid 0, m_last 0, m_data 0, busy 0, done 0, drop_err 0.
REQ-029 Reset asserted mid-DRAIN SHALL abort the stream immediately; no further m_valid until a new collection completes.

Structure
REQ-030 FSM state codes and default DATA_W/ADDR_W SHALL live in the shared sifting package.
REQ-031 Key storage SHALL be one sub-module, siftkey_sdp_ram: simple dual-port, one write port, one registered read port, 1-cycle read latency, inferable as BRAM.
REQ-032 Drain path SHALL use a 2-entry output buffer to meet REQ-020/021 under back-pressure.

Verification
REQ-033 Writes addr 0..7 data 0x100+addr, finish, m_ready=1 -> 8 beats 0x100..0x107, m_last on beat 8, key_count 8, done=1.
REQ-034 Writes addr 0..3, finish, m_ready toggling 1/0 each cycle -> same 4 words in order, data stable while stalled, no duplicates.
REQ-035 Writes addr 5 then addr 2, finish -> key_count 6, 6 beats, beat 6 = addr-5 word.
REQ-036 sifting_finish with no writes -> DONE within 1 cycle, key_count 0, m_valid never high.
REQ-037 Write during DRAIN -> drop_err=1, stream unchanged; clear -> IDLE, drop_err 0, key_count 0.
REQ-038 Reset asserted after beat 3 of 10 -> m_valid 0 next cycle, state IDLE, all outputs at reset values.
